// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and issue-side valid/ready bundles of the decode stage.
interface decode_in_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  modport master (output valid, instruction, pc, input ready);
  modport slave (input valid, instruction, pc, output ready);
endinterface

interface decode_out_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [4:0]      register1;
  logic [4:0]      register2;
  logic [4:0]      registerd;
  logic [6:0]      op_code;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [2:0]      format;
  logic [XLEN-1:0] immediate;
  logic            illegal;
  modport master (output valid, pc, register1, register2, registerd, op_code, func3, func7,
                  format, immediate, illegal, input ready);
  modport slave (input valid, pc, register1, register2, registerd, op_code, func3, func7,
                 format, immediate, illegal, output ready);
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I format classification and immediate build,
// registered output backed by a one-entry skid so in_ready never sees out_ready.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  decode_in_if.slave   in_if,
  decode_out_if.master out_if
);
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            ill;
  } entry_t;
  logic [31:0]     ins;
  logic [2:0]      fmt;
  logic [XLEN-1:0] imm;
  entry_t          dec, m_d, m_q, s_d, s_q;
  logic            m_valid_d, m_valid_q, s_valid_d, s_valid_q;
  logic            acc, drn, adv;
  assign ins = in_if.instruction;
  always_comb begin
    fmt = FMT_X;
    case (ins[6:0])
      7'b0110011: fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: fmt = FMT_I;
      7'b0100011: fmt = FMT_S;
      7'b1100011: fmt = FMT_B;
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111: fmt = FMT_J;
      default: fmt = FMT_X;
    endcase
  end
  // Size casts of signed operands sign-extend each immediate to XLEN.
  always_comb begin
    imm = fmt == FMT_I ? XLEN'($signed(ins[31:20])) :
          fmt == FMT_S ? XLEN'($signed({ins[31:25], ins[11:7]})) :
          fmt == FMT_B ? XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) :
          fmt == FMT_U ? XLEN'($signed({ins[31:12], 12'b0})) :
          fmt == FMT_J ? XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) :
          '0;
    dec = {in_if.pc, ins, fmt, imm, fmt == FMT_X};
  end
  // M advances when empty or draining; it refills from S first so order is kept.
  always_comb begin
    acc       = in_if.valid && !s_valid_q;
    drn       = m_valid_q && out_if.ready;
    adv       = !m_valid_q || drn;
    m_valid_d = flush ? 1'b0 : adv ? (s_valid_q || acc) : 1'b1;
    s_valid_d = flush ? 1'b0 : adv ? 1'b0 : (s_valid_q || acc);
    m_d       = !adv ? m_q : s_valid_q ? s_q : acc ? dec : m_q;
    s_d       = (!adv && acc) ? dec : s_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end
  assign in_if.ready      = !s_valid_q;
  assign out_if.valid     = m_valid_q;
  assign out_if.pc        = m_q.pc;
  assign out_if.register1 = m_q.instr[19:15];
  assign out_if.register2 = m_q.instr[24:20];
  assign out_if.registerd = m_q.instr[11:7];
  assign out_if.op_code   = m_q.instr[6:0];
  assign out_if.func3     = m_q.instr[14:12];
  assign out_if.func7     = m_q.instr[31:25];
  assign out_if.format    = m_q.fmt;
  assign out_if.immediate = m_q.imm;
  assign out_if.illegal   = m_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table of hand-decoded vectors fed to 32- and 64-bit stages in lockstep,
// scoreboarded in acceptance order, plus back-pressure, flush and async-reset sequences.
module tb_decode_stage;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clock = ~clock;
  decode_in_if  #(.XLEN(32)) i32 ();
  decode_out_if #(.XLEN(32)) o32 ();
  decode_in_if  #(.XLEN(64)) i64 ();
  decode_out_if #(.XLEN(64)) o64 ();
  decode_stage #(.XLEN(32)) d32 (.clock(clock), .reset(reset), .flush(flush), .in_if(i32), .out_if(o32));
  decode_stage #(.XLEN(64)) d64 (.clock(clock), .reset(reset), .flush(flush), .in_if(i64), .out_if(o64));
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } vec_t;
  vec_t tbl[16];
  vec_t cur, e;
  vec_t q[$];
  int total = 0, bad = 0, popped = 0, n = 0, p0 = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] w);
    total++;
    if (a !== w) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, w);
    end
  endtask
  task automatic add(input logic [31:0] ins, input logic [2:0] f, input logic [63:0] im, input logic il);
    tbl[n].instr = ins;
    tbl[n].fmt   = f;
    tbl[n].imm   = im;
    tbl[n].ill   = il;
    tbl[n].pc    = {32'hA5A50000 + 32'(n), 32'h80000000 + 32'(n) * 4};
    n++;
  endtask
  task automatic drive(input int k);
    cur = tbl[k];
    i32.valid = 1'b1; i32.instruction = tbl[k].instr; i32.pc = tbl[k].pc[31:0];
    i64.valid = 1'b1; i64.instruction = tbl[k].instr; i64.pc = tbl[k].pc;
  endtask
  task automatic idle;
    i32.valid = 1'b0;
    i64.valid = 1'b0;
  endtask
  task automatic set_ready(input logic r);
    o32.ready = r;
    o64.ready = r;
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic wait_drain(input string nm);
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    chk(nm, 64'(q.size()), 64'd0);
  endtask
  always @(negedge clock) begin
    if (reset) q.delete();
    else begin
      if (o32.valid && o32.ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out got pc=%h want=no entry", o32.pc);
        end else begin
          e = q.pop_front();
          popped++;
          chk("d32.fields", 64'({o32.func7, o32.register2, o32.register1, o32.func3, o32.registerd, o32.op_code}), 64'(e.instr));
          chk("d32.pc", 64'(o32.pc), 64'(e.pc[31:0]));
          chk("d32.format", 64'(o32.format), 64'(e.fmt));
          chk("d32.imm", 64'(o32.immediate), 64'(e.imm[31:0]));
          chk("d32.illegal", 64'(o32.illegal), 64'(e.ill));
          chk("d64.valid", 64'(o64.valid), 64'd1);
          chk("d64.fields", 64'({o64.func7, o64.register2, o64.register1, o64.func3, o64.registerd, o64.op_code}), 64'(e.instr));
          chk("d64.pc", o64.pc, e.pc);
          chk("d64.format", 64'(o64.format), 64'(e.fmt));
          chk("d64.imm", o64.immediate, e.imm);
          chk("d64.illegal", 64'(o64.illegal), 64'(e.ill));
        end
      end
      if (flush) q.delete();
      else if (i32.valid && i32.ready) q.push_back(cur);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    set_ready(1'b1);
    i32.instruction = '0; i32.pc = '0;
    i64.instruction = '0; i64.pc = '0;
    add(32'hFFF10093, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    add(32'h00512423, 3'd2, 64'h0000000000000008, 1'b0);
    add(32'h001000EF, 3'd5, 64'h0000000000000800, 1'b0);
    add(32'h800001B7, 3'd4, 64'hFFFFFFFF80000000, 1'b0);
    add(32'h00000000, 3'd7, 64'h0000000000000000, 1'b1);
    add(32'h002081B3, 3'd0, 64'h0000000000000000, 1'b0);
    add(32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    add(32'h12345297, 3'd4, 64'h0000000012345000, 1'b0);
    add(32'hFF812083, 3'd1, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    add(32'hFE512E23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    add(32'h00000073, 3'd1, 64'h0000000000000000, 1'b0);
    add(32'h00000012, 3'd7, 64'h0000000000000000, 1'b1);
    add(32'h7FF080E7, 3'd1, 64'h00000000000007FF, 1'b0);
    add(32'h0000000F, 3'd1, 64'h0000000000000000, 1'b0);
    add(32'h0000007F, 3'd7, 64'h0000000000000000, 1'b1);
    add(32'hFFFFF06F, 3'd5, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    #2 reset = 1'b1;
    tick();
    tick();
    chk("rst.out_valid", 64'(o32.valid), 64'd0);
    chk("rst.in_ready", 64'(i32.ready), 64'd1);
    chk("rst.pc", 64'(o32.pc), 64'd0);
    chk("rst.fields", 64'({o32.func7, o32.register2, o32.register1, o32.func3, o32.registerd, o32.op_code}), 64'd0);
    chk("rst.format", 64'(o32.format), 64'd0);
    chk("rst.imm", 64'(o32.immediate), 64'd0);
    chk("rst.illegal", 64'(o32.illegal), 64'd0);
    chk("rst64.out_valid", 64'(o64.valid), 64'd0);
    chk("rst64.in_ready", 64'(i64.ready), 64'd1);
    chk("rst64.imm", o64.immediate, 64'd0);
    reset = 1'b0;
    drive(0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("latency.out_valid", 64'(o32.valid), 64'd1);
      drive(k);
    end
    tick();
    chk("latency.out_valid", 64'(o32.valid), 64'd1);
    idle();
    tick();
    chk("stream.idle_valid", 64'(o32.valid), 64'd0);
    chk("stream.drained", 64'(q.size()), 64'd0);
    p0 = popped;
    set_ready(1'b0);
    drive(1);
    tick();
    chk("bp.in_ready_a", 64'(i32.ready), 64'd1);
    drive(6);
    tick();
    chk("bp.in_ready_full", 64'(i32.ready), 64'd0);
    chk("bp.out_valid", 64'(o32.valid), 64'd1);
    chk("bp.pc_a", 64'(o32.pc), 64'(tbl[1].pc[31:0]));
    drive(7);
    tick();
    chk("bp.in_ready_hold", 64'(i32.ready), 64'd0);
    chk("bp.pc_stable", 64'(o32.pc), 64'(tbl[1].pc[31:0]));
    chk("bp.imm_stable", o64.immediate, tbl[1].imm);
    set_ready(1'b1);
    tick();
    for (int k = 0; k < 5 && !i32.ready; k++) tick();
    chk("bp.in_ready_back", 64'(i32.ready), 64'd1);
    tick();
    idle();
    wait_drain("bp.drained");
    chk("bp.count", 64'(popped - p0), 64'd3);
    set_ready(1'b0);
    drive(2);
    tick();
    drive(3);
    tick();
    chk("flush.full", 64'(i32.ready), 64'd0);
    flush = 1'b1;
    drive(4);
    tick();
    flush = 1'b0;
    idle();
    chk("flush.out_valid", 64'(o32.valid), 64'd0);
    chk("flush.in_ready", 64'(i32.ready), 64'd1);
    chk("flush64.out_valid", 64'(o64.valid), 64'd0);
    set_ready(1'b1);
    tick();
    tick();
    chk("flush.stays_empty", 64'(o32.valid), 64'd0);
    drive(8);
    tick();
    drive(9);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst.out_valid", 64'(o32.valid), 64'd0);
    chk("arst.in_ready", 64'(i32.ready), 64'd1);
    chk("arst64.out_valid", 64'(o64.valid), 64'd0);
    chk("arst.imm", 64'(o32.immediate), 64'd0);
    idle();
    tick();
    tick();
    reset = 1'b0;
    drive(3);
    tick();
    chk("post_rst.out_valid", 64'(o32.valid), 64'd1);
    idle();
    wait_drain("post_rst.drained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
